keypad_input_conditioner: RTL and testbench
===========================================

KEYPAD_INPUT_CONDITIONER -- requirements
Module: keypad_input_conditioner

Interface
REQ-001 SHALL have parameter N_COLS, default 4, number of keypad column inputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop stages per synchronizer chain; legal values are 2 or more.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive disagreeing cycles required to accept a change; legal values are 1 or more.
REQ-004 SHALL have parameter TICK_DIV, default 25000, scan-tick period in clk cycles; legal values are 2 or more.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port col  input  N_COLS  raw asynchronous keypad columns, active-low (0 = key pressed).
REQ-008 SHALL have port col_sync  output  N_COLS  synchronized columns, active-high.
REQ-009 SHALL have port col_stable  output  N_COLS  debounced columns, active-high.
REQ-010 SHALL have port press  output  N_COLS  one-cycle pulse per column on a debounced 0->1 transition.
REQ-011 SHALL have port release  output  N_COLS  one-cycle pulse per column on a debounced 1->0 transition.
REQ-012 SHALL have port any_pressed  output  1  OR-reduction of col_stable.
REQ-013 SHALL have port scan_tick  output  1  one-cycle pulse every TICK_DIV cycles, used as the row-scan strobe.

Function
REQ-014 SHALL invert each col bit on entry to the synchronizer, then pass it through an SYNC_STAGES-deep shift register; col_sync is the last stage.
REQ-015 SHALL keep one debounce counter per column, sized to hold DEBOUNCE_CYCLES-1, and clear it in any cycle where col_sync equals col_stable.
REQ-016 SHALL increment the counter in each cycle where col_sync differs from col_stable and the counter is below DEBOUNCE_CYCLES-1.
REQ-017 SHALL, when the counter is at DEBOUNCE_CYCLES-1 and col_sync still differs, toggle col_stable and clear the counter in the same edge.
REQ-018 SHALL give an end-to-end latency from a clean col change to the col_stable update of exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges.
REQ-019 SHALL reject any glitch shorter than DEBOUNCE_CYCLES synchronized cycles, leaving col_stable unchanged and the counter cleared.
REQ-020 SHALL assert press[i] or release[i] in the same cycle col_stable[i] becomes 1 or 0 respectively; neither output is ever high for more than one cycle.
REQ-021 SHALL debounce columns independently, so simultaneous transitions on several columns pulse together.
REQ-022 SHALL run a prescaler from 0 to TICK_DIV-1 and wrap to 0; scan_tick is high only while the count equals TICK_DIV-1.
REQ-023 SHALL drive any_pressed combinationally from col_stable.

Reset
REQ-024 SHALL, while reset is 0 at a clock edge, clear all synchronizer stages, debounce counters, col_stable, press, release and the prescaler.
REQ-025 SHALL therefore hold all outputs at 0 during reset.
REQ-026 SHALL make the first scan_tick after reset release occur at edge TICK_DIV.
REQ-027 SHALL, on reset mid-debounce, discard the pending change without generating any pulse.

Configuration
REQ-028 SHALL, with macro KEYPAD_EDGE_PULSE_EN defined, implement press and release as specified above.
REQ-029 SHALL, without KEYPAD_EDGE_PULSE_EN defined, tie press and release to constant 0 and omit their registers, with all other behaviour unchanged.

Structure
REQ-030 SHALL place the default parameter constants (KP_N_COLS, KP_SYNC_STAGES, KP_DEBOUNCE_CYCLES, KP_TICK_DIV) in shared package keypad_pkg.
REQ-031 SHALL implement per-column debounce as sub-module debounce_chan, with one instance per column via generate.

Verification (N_COLS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-032 SHALL cover reset: hold reset=0 for 3 cycles with col=4'b0000 -> all outputs 0 throughout.
REQ-033 SHALL cover a clean press: col=4'b1110 from edge 0 -> col_stable=4'b0001 and press=4'b0001 at edge 6 only, and any_pressed=1 from edge 6.
REQ-034 SHALL cover bounce: col[1] low for 3 cycles then high -> col_stable, press and release stay 0.
REQ-035 SHALL cover a clean release: after REQ-033, col=4'b1111 -> release=4'b0001 for one cycle at 6 edges later, and col_stable=0.
REQ-036 SHALL cover the tick with mid-count reset: scan_tick high at edges 8 and 16; reset pulsed at edge 19 -> next tick at edge 27.
REQ-037 SHALL cover the macro-off build: rerun REQ-033 without KEYPAD_EDGE_PULSE_EN -> press stays 0 while col_stable still reaches 4'b0001 at edge 6.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared defaults and helpers for the keypad input conditioner.
package keypad_pkg;

  localparam int KP_N_COLS          = 4;
  localparam int KP_SYNC_STAGES     = 2;
  localparam int KP_DEBOUNCE_CYCLES = 50000;
  localparam int KP_TICK_DIV        = 25000;

  // Bits needed for a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced keypad column: accepts a change after DEBOUNCE_CYCLES consecutive
// disagreeing cycles. Edge pulses exist only when KEYPAD_EDGE_PULSE_EN is defined.
module debounce_chan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
`ifdef KEYPAD_EDGE_PULSE_EN
  ,
  output logic press,
  output logic release_pulse
`endif
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          differ;
  logic          expire;

  assign differ = din ^ stable;
  assign expire = differ && (cnt == CNT_MAX);

  // Any agreeing cycle restarts the count, so short glitches never accumulate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef KEYPAD_EDGE_PULSE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= expire & din;
      release_pulse <= expire & ~din;
    end
  end
`endif

endmodule

// File: rtl/keypad_input_conditioner.sv
// Keypad column conditioner: synchronize, debounce, edge pulses and row-scan tick.
// Macro KEYPAD_EDGE_PULSE_EN enables the press/release_pulse registers.
module keypad_input_conditioner
  import keypad_pkg::*;
#(
  parameter int N_COLS          = KP_N_COLS,
  parameter int SYNC_STAGES     = KP_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = KP_TICK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_COLS-1:0] col,
  output logic [N_COLS-1:0] col_sync,
  output logic [N_COLS-1:0] col_stable,
  output logic [N_COLS-1:0] press,
  // release is a reserved word, hence the longer name
  output logic [N_COLS-1:0] release_pulse,
  output logic              any_pressed,
  output logic              scan_tick
);

  localparam int            TW       = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic [N_COLS-1:0] sync_q [SYNC_STAGES];
  logic [TW-1:0]     presc;

  // Columns are active-low on the pins; invert before the first flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ~col;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign col_sync = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < N_COLS; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .din          (col_sync[g]),
      .stable       (col_stable[g])
`ifdef KEYPAD_EDGE_PULSE_EN
      ,
      .press        (press[g]),
      .release_pulse(release_pulse[g])
`endif
    );
  end

`ifndef KEYPAD_EDGE_PULSE_EN
  assign press         = '0;
  assign release_pulse = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset || presc == TICK_MAX) presc <= '0;
    else                             presc <= presc + TW'(1);
  end

  assign scan_tick   = (presc == TICK_MAX);
  assign any_pressed = |col_stable;

endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Bench for keypad_input_conditioner: directed steps plus random bouncing columns
// checked every cycle against a delay-line/window reference model.
module tb_keypad_input_conditioner;

  localparam int NC = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int TD = 8;
`ifdef KEYPAD_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] col;
  logic [NC-1:0] col_sync, col_stable, press, release_pulse;
  logic          any_pressed, scan_tick;

  always #5 clk = ~clk;

  keypad_input_conditioner #(
    .N_COLS(NC), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .col          (col),
    .col_sync     (col_sync),
    .col_stable   (col_stable),
    .press        (press),
    .release_pulse(release_pulse),
    .any_pressed  (any_pressed),
    .scan_tick    (scan_tick)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: dl_q[k] is synchronizer stage k, win_q holds the last DB
  // synchronized samples seen by the debouncer (newest first)
  logic [NC-1:0] dl_q[$];
  logic [NC-1:0] win_q[$];
  logic [NC-1:0] m_stable, m_press, m_release;
  int            m_presc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [NC-1:0] col_v, input logic rst_v);
    bit all_diff;
    if (!rst_v) begin
      dl_q = {};
      repeat (SS) dl_q.push_back('0);
      win_q     = {};
      m_stable  = '0;
      m_press   = '0;
      m_release = '0;
      m_presc   = 0;
    end else begin
      win_q.push_front(dl_q[SS-1]);
      if (win_q.size() > DB) void'(win_q.pop_back());
      m_press   = '0;
      m_release = '0;
      for (int i = 0; i < NC; i++) begin
        all_diff = (win_q.size() == DB);
        foreach (win_q[j]) if (win_q[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i]) m_press[i] = PULSE_EN;
          else             m_release[i] = PULSE_EN;
        end
      end
      dl_q.push_front(~col_v);
      void'(dl_q.pop_back());
      m_presc = (m_presc + 1) % TD;
    end
  endtask

  task automatic check_all();
    chk("col_sync",    32'(col_sync),      32'(dl_q[SS-1]));
    chk("col_stable",  32'(col_stable),    32'(m_stable));
    chk("press",       32'(press),         32'(m_press));
    chk("release",     32'(release_pulse), 32'(m_release));
    chk("any_pressed", 32'(any_pressed),   32'(|m_stable));
    chk("scan_tick",   32'(scan_tick),     32'(m_presc == TD - 1));
  endtask

  // driver: inputs change on the falling edge, outputs checked 1 after the rising edge
  task automatic step(input logic [NC-1:0] col_v, input logic rst_v);
    @(negedge clk);
    col   = col_v;
    reset = rst_v;
    @(posedge clk);
    model_edge(col_v, rst_v);
    #1;
    check_all();
  endtask

  logic [NC-1:0] seen;
  logic [NC-1:0] pe;
  logic [NC-1:0] rv;
  int            len;
  logic          rb;

  initial begin
    reset = 1'b0;
    col   = '1;
    pe    = PULSE_EN ? 4'b0001 : 4'b0000;

    // reset held three cycles with every key down
    repeat (3) begin
      step(4'b0000, 1'b0);
      chk("reset_outs", 32'({col_sync, col_stable, press, release_pulse, any_pressed, scan_tick}), 32'd0);
    end
    repeat (10) step(4'b1111, 1'b1);

    // bounce shorter than the debounce window
    seen = '0;
    repeat (3) begin
      step(4'b1101, 1'b1);
      seen |= col_stable | press | release_pulse;
    end
    repeat (10) begin
      step(4'b1111, 1'b1);
      seen |= col_stable | press | release_pulse;
    end
    chk("bounce_ignored", 32'(seen), 32'd0);

    // clean press: value observed at edge 6 is the one present after edge 5
    for (int k = 0; k < 8; k++) begin
      step(4'b1110, 1'b1);
      chk("press_stable", 32'(col_stable), (k >= 5) ? 32'd1 : 32'd0);
      chk("press_pulse",  32'(press), (k == 5) ? 32'(pe) : 32'd0);
      chk("press_any",    32'(any_pressed), (k >= 5) ? 32'd1 : 32'd0);
    end

    // clean release
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b1);
      chk("release_stable", 32'(col_stable), (k >= 5) ? 32'd0 : 32'd1);
      chk("release_pulse",  32'(release_pulse), (k == 5) ? 32'(pe) : 32'd0);
    end

    // scan tick from reset, with a reset pulse at edge 19
    step(4'b1111, 1'b0);
    for (int e = 1; e <= 26; e++) begin
      step(4'b1111, (e != 19));
      chk("tick_sched", 32'(scan_tick), (e == 7 || e == 15 || e == 26) ? 32'd1 : 32'd0);
    end

    // reset in the middle of a pending press discards it
    repeat (4) step(4'b1110, 1'b1);
    step(4'b1110, 1'b0);
    seen = '0;
    repeat (8) begin
      step(4'b1111, 1'b1);
      seen |= col_stable | press | release_pulse;
    end
    chk("mid_debounce_reset", 32'(seen), 32'd0);

    // random bouncing columns with occasional reset
    repeat (300) begin
      rv  = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      rb  = ($urandom_range(0, 39) != 0);
      repeat (len) step(rv, rb);
    end
    repeat (12) step(4'b1111, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
